// File: rtl/tmds_encoder_hdmi.sv
// Multi-lane pipelined TMDS encoder: control, 8b/10b video, TERC4 data island and guard band symbols.
// Define TMDS_BIAS_MON_EN to expose the registered per-lane running disparity on o_bias.
module tmds_encoder_hdmi #(
  parameter int NCH     = 3,
  parameter int LATENCY = 2,
  parameter int BIAS_W  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ce,
  input  logic [1:0]            i_mode,
  input  logic                  i_gb_di,
  input  logic [NCH*8-1:0]      i_data,
  input  logic [NCH*2-1:0]      i_ctrl,
  input  logic [NCH*4-1:0]      i_terc,
  output logic [NCH*10-1:0]     o_tmds,
  output logic [1:0]            o_mode
`ifdef TMDS_BIAS_MON_EN
  ,
  output logic [NCH*BIAS_W-1:0] o_bias
`endif
);

  localparam logic [1:0] M_CTRL  = 2'b00;
  localparam logic [1:0] M_VIDEO = 2'b01;
  localparam logic [1:0] M_TERC  = 2'b10;
  localparam logic [1:0] M_GUARD = 2'b11;
  localparam logic [9:0] SYM_CTRL0 = 10'b1101010100;
  localparam logic [9:0] GB_A      = 10'b1011001100;
  localparam logic [9:0] GB_B      = 10'b0100110011;

  if (NCH < 1 || NCH > 4) begin : g_bad_nch
    $error("tmds_encoder_hdmi: NCH must be in 1..4");
  end
  if (LATENCY < 1 || LATENCY > 2) begin : g_bad_latency
    $error("tmds_encoder_hdmi: LATENCY must be 1 or 2");
  end
  if (BIAS_W < 6) begin : g_bad_bias_w
    $error("tmds_encoder_hdmi: BIAS_W must be at least 6");
  end

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] t);
    case (t)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  // Symbol for every non-video mode; in data-island guard, lane 0 carries the caller-packed TERC4 nibble.
  function automatic logic [9:0] fixed_sym(input logic [1:0] mode, input logic gb_di, input int lane,
                                           input logic [1:0] c, input logic [3:0] t);
    case (mode)
      M_TERC:  return terc4_sym(t);
      M_GUARD: begin
        if (gb_di) return (lane == 0) ? terc4_sym(t) : GB_B;
        else       return (lane == 1) ? GB_B : GB_A;
      end
      default: return ctrl_sym(c);
    endcase
  endfunction

  function automatic logic [8:0] qm_calc(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = 4'($countones(d));
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q[0]     = d[0];
    for (int k = 1; k < 8; k++) q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  // Ones minus zeros of q_m[7:0], two's complement in 5 bits (-8..+8).
  function automatic logic [4:0] bal_calc(input logic [7:0] q);
    logic [3:0] n;
    n = 4'($countones(q));
    return {n, 1'b0} - 5'd8;
  endfunction

  // Returns {next_bias, symbol}; bias arithmetic is two's complement modulo 2^BIAS_W.
  function automatic logic [BIAS_W+9:0] video_enc(input logic [8:0] qm, input logic [4:0] bal,
                                                  input logic [BIAS_W-1:0] bias);
    logic [BIAS_W-1:0] balx, two_q8, two_nq8, nb;
    logic [9:0]        sym;
    balx    = {{(BIAS_W-5){bal[4]}}, bal};
    two_q8  = qm[8] ? BIAS_W'(2) : '0;
    two_nq8 = qm[8] ? '0 : BIAS_W'(2);
    if (bias == '0 || bal == '0) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nb  = qm[8] ? bias + balx : bias - balx;
    end else if (bias[BIAS_W-1] == bal[4]) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nb  = bias + two_q8 - balx;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nb  = bias + balx - two_nq8;
    end
    return {nb, sym};
  endfunction

  logic [8:0] qm_d  [NCH];
  logic [4:0] bal_d [NCH];
  logic [9:0] fix_d [NCH];
  logic [8:0] qm_s  [NCH];
  logic [4:0] bal_s [NCH];
  logic [9:0] fix_s [NCH];
  logic [1:0] mode_s;

  for (genvar g = 0; g < NCH; g++) begin : g_lane_pre
    assign qm_d[g]  = qm_calc(i_data[8*g +: 8]);
    assign bal_d[g] = bal_calc(qm_d[g][7:0]);
    assign fix_d[g] = fixed_sym(i_mode, i_gb_di, g, i_ctrl[2*g +: 2], i_terc[4*g +: 4]);
  end

  if (LATENCY == 2) begin : g_stage1
    logic [8:0] qm_q  [NCH];
    logic [4:0] bal_q [NCH];
    logic [9:0] fix_q [NCH];
    logic [1:0] mode_q;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        mode_q <= M_CTRL;
        for (int i = 0; i < NCH; i++) begin
          qm_q[i]  <= '0;
          bal_q[i] <= '0;
          fix_q[i] <= SYM_CTRL0;
        end
      end else if (i_ce) begin
        mode_q <= i_mode;
        for (int i = 0; i < NCH; i++) begin
          qm_q[i]  <= qm_d[i];
          bal_q[i] <= bal_d[i];
          fix_q[i] <= fix_d[i];
        end
      end
    end

    assign mode_s = mode_q;
    assign qm_s   = qm_q;
    assign bal_s  = bal_q;
    assign fix_s  = fix_q;
  end else begin : g_stage1_bypass
    assign mode_s = i_mode;
    assign qm_s   = qm_d;
    assign bal_s  = bal_d;
    assign fix_s  = fix_d;
  end

  logic [9:0]        tmds_d [NCH];
  logic [BIAS_W-1:0] bias_d [NCH];
  logic [9:0]        tmds_q [NCH];
  logic [BIAS_W-1:0] bias_q [NCH];
  logic [1:0]        mode_q;

  // Any non-video symbol clears the lane bias, so the next video symbol starts balanced.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tmds_d[i] = fix_s[i];
      bias_d[i] = '0;
      if (mode_s == M_VIDEO) {bias_d[i], tmds_d[i]} = video_enc(qm_s[i], bal_s[i], bias_q[i]);
    end
  end

  // i_ce low freezes every register; reset overrides it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mode_q <= M_CTRL;
      for (int i = 0; i < NCH; i++) begin
        tmds_q[i] <= SYM_CTRL0;
        bias_q[i] <= '0;
      end
    end else if (i_ce) begin
      mode_q <= mode_s;
      for (int i = 0; i < NCH; i++) begin
        tmds_q[i] <= tmds_d[i];
        bias_q[i] <= bias_d[i];
      end
    end
  end

  assign o_mode = mode_q;
  for (genvar g = 0; g < NCH; g++) begin : g_lane_out
    assign o_tmds[10*g +: 10] = tmds_q[g];
`ifdef TMDS_BIAS_MON_EN
    assign o_bias[BIAS_W*g +: BIAS_W] = bias_q[g];
`endif
  end

endmodule
